// File: rtl/int_ack_ctrl.sv
// Interrupt acknowledge controller: picks the highest-priority preempting source at the
// MEM boundary, redirects to its vector, clears the latch, and unwinds nesting on returns.
module int_ack_ctrl #(
  parameter logic [31:0] VEC0 = 32'h0000_0100,
  parameter logic [31:0] VEC1 = 32'h0000_0200,
  parameter logic [31:0] VEC2 = 32'h0000_0300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  IR,
  input  logic        ie,
  input  logic        inst_valid,
  input  logic [31:0] pc_mem,
  input  logic        is_ret,
  output logic        stall_req,
  output logic        int_take,
  output logic [31:0] int_vec,
  output logic        ret_take,
  output logic [31:0] ret_pc,
  output logic        Clr,
  output logic [2:0]  ClrInt,
  output logic [2:0]  isr,
  output logic        busy
);

  typedef enum logic [1:0] {RUN, ENTER, LEAVE} state_t;

  state_t      state, state_nx;
  logic [1:0]  sel, sel_nx;
  logic [1:0]  pop_lvl, pop_lvl_nx;
  logic [1:0]  sp;
  logic [31:0] epc, epc_nx;
  logic [31:0] pop_pc, pop_pc_nx;
  logic [31:0] stack [0:2];
  logic [1:0]  cur_rank, cand_rank;
  logic        req, ret_req;

  // Rank 0 means "nothing"; rank n means bit n-1 is the highest set bit.
  function automatic logic [1:0] rank_of(input logic [2:0] v);
    if (v[2])      return 2'd3;
    else if (v[1]) return 2'd2;
    else if (v[0]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [31:0] vec_of(input logic [1:0] s);
    case (s)
      2'd0:    return VEC0;
      2'd1:    return VEC1;
      default: return VEC2;
    endcase
  endfunction

  assign cur_rank  = rank_of(isr);
  assign cand_rank = rank_of(IR);
  assign ret_req   = is_ret & inst_valid & (isr != 3'b000);
  assign req       = ie & inst_valid & ~is_ret & (cand_rank > cur_rank);
  assign busy      = (state != RUN);

  // NOTE: every output and next-state value gets a default first so no latch is inferred.
  always_comb begin
    state_nx   = state;
    sel_nx     = sel;
    epc_nx     = epc;
    pop_pc_nx  = pop_pc;
    pop_lvl_nx = pop_lvl;
    stall_req  = 1'b0;
    int_take   = 1'b0;
    int_vec    = '0;
    ret_take   = 1'b0;
    ret_pc     = '0;
    Clr        = 1'b0;
    ClrInt     = 3'b000;
    case (state)
      RUN: begin
        if (ret_req) begin
          stall_req  = 1'b1;
          pop_pc_nx  = stack[sp - 2'd1];
          pop_lvl_nx = cur_rank - 2'd1;
          state_nx   = LEAVE;
        end else if (req) begin
          stall_req = 1'b1;
          sel_nx    = cand_rank - 2'd1;
          epc_nx    = pc_mem;
          state_nx  = ENTER;
        end
      end
      ENTER: begin
        int_take = 1'b1;
        int_vec  = vec_of(sel);
        Clr      = 1'b1;
        ClrInt   = 3'b001 << sel;
        state_nx = RUN;
      end
      LEAVE: begin
        ret_take = 1'b1;
        ret_pc   = pop_pc;
        state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
    // A reset cycle must not leak a redirect or a latch clear.
    if (!rst) begin
      stall_req = 1'b0;
      int_take  = 1'b0;
      int_vec   = '0;
      ret_take  = 1'b0;
      ret_pc    = '0;
      Clr       = 1'b0;
      ClrInt    = 3'b000;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= RUN;
      isr     <= 3'b000;
      sp      <= 2'd0;
      sel     <= 2'd0;
      epc     <= '0;
      pop_pc  <= '0;
      pop_lvl <= 2'd0;
    end else begin
      state   <= state_nx;
      sel     <= sel_nx;
      epc     <= epc_nx;
      pop_pc  <= pop_pc_nx;
      pop_lvl <= pop_lvl_nx;
      if (state == ENTER) begin
        isr[sel] <= 1'b1;
        sp       <= sp + 2'd1;
      end else if (state == LEAVE) begin
        isr[pop_lvl] <= 1'b0;
        sp           <= sp - 2'd1;
      end
    end
  end

  // NOTE: the EPC stack is not reset; sp=0 makes its contents unreachable.
  always_ff @(posedge clk) begin
    if (rst && state == ENTER) stack[sp] <= epc;
  end

endmodule

// File: tb/tb_int_ack_ctrl.sv
// Self-checking bench for int_ack_ctrl: a queue-based nesting model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_int_ack_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  IR;
  logic        ie, inst_valid, is_ret;
  logic [31:0] pc_mem;
  logic        stall_req, int_take, ret_take, Clr, busy;
  logic [31:0] int_vec, ret_pc;
  logic [2:0]  ClrInt, isr;

  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;

  int_ack_ctrl dut (
    .clk(clk), .rst(rst), .IR(IR), .ie(ie), .inst_valid(inst_valid),
    .pc_mem(pc_mem), .is_ret(is_ret), .stall_req(stall_req),
    .int_take(int_take), .int_vec(int_vec), .ret_take(ret_take),
    .ret_pc(ret_pc), .Clr(Clr), .ClrInt(ClrInt), .isr(isr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: in-service levels with their saved PCs as a stack of pairs.
  localparam int PH_RUN = 0, PH_ENTER = 1, PH_LEAVE = 2;
  int          lv_q[$];
  logic [31:0] pc_q[$];
  int          m_phase = PH_RUN;
  int          m_sel;
  logic [31:0] m_epc, m_pop_pc;

  always @(negedge clk) begin
    if (armed) begin
      logic [2:0]  e_isr, e_clrint;
      logic        e_stall, e_take, e_ret, e_clr;
      logic [31:0] e_vec, e_rpc;
      int cur, cand;
      bit ret_c, req_c;
      e_isr = 3'b000;
      cur = -1;
      foreach (lv_q[i]) begin
        e_isr = e_isr | (3'b001 << lv_q[i]);
        if (lv_q[i] > cur) cur = lv_q[i];
      end
      cand = -1;
      for (int i = 0; i < 3; i++) if (IR[i]) cand = i;
      ret_c = is_ret && inst_valid && (lv_q.size() > 0);
      req_c = ie && inst_valid && !is_ret && (cand > cur);
      e_stall = 0; e_take = 0; e_ret = 0; e_clr = 0;
      e_vec = 0; e_rpc = 0; e_clrint = 0;
      if (rst) begin
        if (m_phase == PH_ENTER) begin
          e_take = 1; e_clr = 1;
          e_vec = 32'h100 * (m_sel + 1);
          e_clrint = 3'b001 << m_sel;
        end else if (m_phase == PH_LEAVE) begin
          e_ret = 1; e_rpc = m_pop_pc;
        end else begin
          e_stall = ret_c || req_c;
        end
      end
      check("stall_req", 32'(stall_req), 32'(e_stall));
      check("int_take", 32'(int_take), 32'(e_take));
      check("int_vec", int_vec, e_vec);
      check("ret_take", 32'(ret_take), 32'(e_ret));
      check("ret_pc", ret_pc, e_rpc);
      check("Clr", 32'(Clr), 32'(e_clr));
      check("ClrInt", 32'(ClrInt), 32'(e_clrint));
      check("isr", 32'(isr), 32'(e_isr));
      check("busy", 32'(busy), 32'(m_phase != PH_RUN));
      // Advance the model to the state after the coming rising edge.
      if (!rst) begin
        lv_q.delete(); pc_q.delete(); m_phase = PH_RUN;
      end else if (m_phase == PH_ENTER) begin
        lv_q.push_back(m_sel); pc_q.push_back(m_epc); m_phase = PH_RUN;
      end else if (m_phase == PH_LEAVE) begin
        void'(lv_q.pop_back()); void'(pc_q.pop_back()); m_phase = PH_RUN;
      end else if (ret_c) begin
        m_pop_pc = pc_q[$]; m_phase = PH_LEAVE;
      end else if (req_c) begin
        m_sel = cand; m_epc = pc_mem; m_phase = PH_ENTER;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; IR = 0; ie = 0; inst_valid = 0; is_ret = 0; pc_mem = 0;
    tick();
    armed = 1;
    tick(); tick();
    rst = 1; #1;
    check("reset isr", 32'(isr), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset int_take", 32'(int_take), 32'h0);

    // 1: single entry to source 1, then return
    IR = 3'b010; ie = 1; inst_valid = 1; pc_mem = 32'h40; #1;
    check("t1 stall", 32'(stall_req), 32'h1);
    tick();
    check("t1 int_take", 32'(int_take), 32'h1);
    check("t1 int_vec", int_vec, 32'h200);
    check("t1 Clr", 32'(Clr), 32'h1);
    check("t1 ClrInt", 32'(ClrInt), 32'h2);
    check("t1 stall in ENTER", 32'(stall_req), 32'h0);
    IR = 0;
    tick();
    check("t1 isr", 32'(isr), 32'h2);
    is_ret = 1; pc_mem = 32'h200;
    tick();
    check("t1 ret_pc", ret_pc, 32'h40);
    is_ret = 0;
    tick();

    // 2: nesting source 0 then source 2
    IR = 3'b001; pc_mem = 32'h40;
    tick(); IR = 0;
    tick();
    check("t2 isr0", 32'(isr), 32'h1);
    IR = 3'b100; pc_mem = 32'h104; #1;
    check("t2 stall", 32'(stall_req), 32'h1);
    tick();
    check("t2 int_vec", int_vec, 32'h300);
    IR = 0;
    tick();
    check("t2 isr nested", 32'(isr), 32'h5);
    is_ret = 1; pc_mem = 32'h300;
    tick();
    check("t2 ret_pc1", ret_pc, 32'h104);
    is_ret = 0;
    tick();
    check("t2 isr after ret1", 32'(isr), 32'h1);
    is_ret = 1; pc_mem = 32'h108;
    tick();
    check("t2 ret_pc2", ret_pc, 32'h40);
    is_ret = 0;
    tick();
    check("t2 isr after ret2", 32'(isr), 32'h0);

    // 3: lower priority pending while source 2 in service
    IR = 3'b100; pc_mem = 32'h50;
    tick(); IR = 3'b011;
    tick();
    check("t3 isr", 32'(isr), 32'h4);
    for (int i = 0; i < 3; i++) begin
      pc_mem = 32'h310 + 32'(4 * i); #1;
      check("t3 blocked stall", 32'(stall_req), 32'h0);
      tick();
      check("t3 blocked take", 32'(int_take), 32'h0);
    end
    is_ret = 1; pc_mem = 32'h320;
    tick();
    check("t3 ret_take", 32'(ret_take), 32'h1);
    check("t3 ret_pc", ret_pc, 32'h50);
    is_ret = 0; pc_mem = 32'h60;
    tick();
    check("t3 detect stall", 32'(stall_req), 32'h1);
    check("t3 no take yet", 32'(int_take), 32'h0);
    tick();
    check("t3 int_take", 32'(int_take), 32'h1);
    check("t3 int_vec", int_vec, 32'h200);
    IR = 3'b001;
    tick();
    is_ret = 1; pc_mem = 32'h204;
    tick();
    check("t3 ret_pc src1", ret_pc, 32'h60);
    is_ret = 0; pc_mem = 32'h70;
    tick();
    tick();
    check("t3 int_vec src0", int_vec, 32'h100);
    IR = 0;
    tick();
    check("t3 isr src0", 32'(isr), 32'h1);

    // 4: return and request together: return first
    is_ret = 1; IR = 3'b010; pc_mem = 32'h110;
    tick();
    check("t4 ret_take", 32'(ret_take), 32'h1);
    check("t4 int_take", 32'(int_take), 32'h0);
    check("t4 ret_pc", ret_pc, 32'h70);
    is_ret = 0; pc_mem = 32'h114;
    tick();
    check("t4 detect stall", 32'(stall_req), 32'h1);
    tick();
    check("t4 int_vec", int_vec, 32'h200);
    IR = 0;
    tick();
    check("t4 isr", 32'(isr), 32'h2);
    is_ret = 1; pc_mem = 32'h200;
    tick();
    check("t4 epc from new detect", ret_pc, 32'h114);
    is_ret = 0;
    tick();

    // 5: masking by ie and inst_valid; returns unwind with ie=0
    IR = 3'b111; ie = 0; inst_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5 ie=0 take", 32'(int_take), 32'h0);
      check("t5 ie=0 Clr", 32'(Clr), 32'h0);
    end
    ie = 1; inst_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5 bubble stall", 32'(stall_req), 32'h0);
    end
    inst_valid = 1; pc_mem = 32'h80;
    tick();
    check("t5 int_vec", int_vec, 32'h300);
    check("t5 ClrInt", 32'(ClrInt), 32'h4);
    IR = 3'b011;
    tick();
    ie = 0; is_ret = 1;
    tick();
    check("t5 ret with ie=0", ret_pc, 32'h80);
    is_ret = 0; IR = 0;
    tick();
    check("t5 isr", 32'(isr), 32'h0);
    ie = 1;

    // 6: reset during ENTER, then during LEAVE
    IR = 3'b001; pc_mem = 32'h90;
    tick();
    rst = 0; #1;
    check("t6 take suppressed", 32'(int_take), 32'h0);
    check("t6 Clr suppressed", 32'(Clr), 32'h0);
    tick();
    rst = 1; #1;
    check("t6 isr cleared", 32'(isr), 32'h0);
    check("t6 reentry stall", 32'(stall_req), 32'h1);
    tick();
    check("t6 reentry vec", int_vec, 32'h100);
    IR = 0;
    tick();
    check("t6 isr", 32'(isr), 32'h1);
    is_ret = 1;
    tick();
    rst = 0; #1;
    check("t6 ret suppressed", 32'(ret_take), 32'h0);
    tick();
    rst = 1; is_ret = 0;
    IR = 3'b010; pc_mem = 32'hA0;
    tick();
    IR = 0;
    tick();
    is_ret = 1;
    tick();
    check("t6 stack after reset", ret_pc, 32'hA0);
    is_ret = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
